alu_mc: RTL and testbench

- Parametrised, handshaked successor to the single-cycle combinational ALU.
- Executes the existing op set (ADD, SUB, MUL, DIV, ABS, SLT, SEQ, MIN) plus REM on WIDTH-bit operands.
- Single-cycle ops complete in one clock. DIV/REM run on an iterative restoring divider, one quotient bit per clock.
- Sits between the decode/issue stage and writeback, with valid/ready on both sides so a multi-cycle divide stalls issue instead of constraining timing.

---
 rtl/alu_pkg.sv | 30 +++
 rtl/alu_divider.sv | 80 ++++++++
 rtl/alu_mc.sv | 157 +++++++++++++++
 tb/tb_alu_mc.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared types for the handshaked multi-cycle ALU.
//   alu_op_t  - op-select encoding carried on ALUctrl
//   state_t   - handshake FSM states of alu_mc
//   is_div_op - true for the ops that run on the iterative divider
package alu_pkg;

   localparam int unsigned OP_W = 4;

   typedef enum logic [OP_W-1:0] {
      OpAdd = 4'd0,
      OpSub = 4'd1,
      OpMul = 4'd2,
      OpDiv = 4'd3,
      OpAbs = 4'd4,
      OpSlt = 4'd5,
      OpSeq = 4'd6,
      OpMin = 4'd7,
      OpRem = 4'd8
   } alu_op_t;

   typedef enum logic {
      StIdle = 1'b0,
      StDiv  = 1'b1
   } state_t;

   function automatic logic is_div_op(input alu_op_t op);
      return (op == OpDiv) || (op == OpRem);
   endfunction

endpackage

// File: rtl/alu_divider.sv
// alu_divider: iterative unsigned restoring divider, one quotient bit per clock, MSB first.
//   clk, rst_n          - clock, asynchronous active-low reset
//   start               - latch dividend/divisor and begin (divisor must be non-zero)
//   hold                - freeze on the final step while the consumer cannot take the result
//   dividend, divisor   - operands sampled on start
//   busy                - iterating
//   done                - final step happens on this edge; quotient/remainder valid now
//   quotient, remainder - results of the step being taken this cycle
module alu_divider #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             hold,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder
);

   localparam int unsigned CNT_W = $clog2(WIDTH);

   logic             busy_q;
   logic [CNT_W-1:0] cnt_q;
   logic [WIDTH-1:0] quo_q;   // dividend shifts out the top, quotient bits shift in
   logic [WIDTH-1:0] rem_q;
   logic [WIDTH-1:0] dsr_q;

   logic [WIDTH:0]   shifted;
   logic [WIDTH:0]   diff;
   logic             ge;
   logic [WIDTH-1:0] rem_nxt;
   logic [WIDTH-1:0] quo_nxt;
   logic             last;
   logic             step;

   always_comb begin
      shifted = {rem_q, quo_q[WIDTH-1]};
      diff    = shifted - {1'b0, dsr_q};
      // rem_q < divisor, so shifted < 2*divisor and the borrow alone decides the bit
      ge      = ~diff[WIDTH];
      rem_nxt = ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
      quo_nxt = {quo_q[WIDTH-2:0], ge};
      last    = (cnt_q == '0);
      step    = busy_q && !(last && hold);
   end

   assign busy      = busy_q;
   assign done      = busy_q && last && !hold;
   assign quotient  = quo_nxt;
   assign remainder = rem_nxt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q <= 1'b0;
         cnt_q  <= '0;
         quo_q  <= '0;
         rem_q  <= '0;
         dsr_q  <= '0;
      end else if (start) begin
         busy_q <= 1'b1;
         cnt_q  <= CNT_W'(WIDTH - 1);
         quo_q  <= dividend;
         rem_q  <= '0;
         dsr_q  <= divisor;
      end else if (step) begin
         quo_q <= quo_nxt;
         rem_q <= rem_nxt;
         if (last) begin
            busy_q <= 1'b0;
         end else begin
            cnt_q <= cnt_q - 1'b1;
         end
      end
   end

endmodule

// File: rtl/alu_mc.sv
// alu_mc: handshaked ALU with single-cycle fast ops and an iterative DIV/REM.
//   clk, rst_n            - clock, asynchronous active-low reset
//   in_valid / in_ready   - upstream handshake for ALUop1, ALUop2, ALUctrl
//   out_valid / out_ready - downstream handshake for Result, EQ, div_by_zero
//   EQ                    - operand equality, only for SEQ
//   div_by_zero           - DIV/REM with ALUop2 == 0
//   busy                  - divider iterating
module alu_mc
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned CTRL_W = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WIDTH-1:0]  ALUop1,
   input  logic [WIDTH-1:0]  ALUop2,
   input  logic [CTRL_W-1:0] ALUctrl,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [WIDTH-1:0]  Result,
   output logic              EQ,
   output logic              div_by_zero,
   output logic              busy
);

   state_t           state_q, state_d;
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic             eq_q, eq_d;
   logic             dbz_q, dbz_d;
   logic             rem_sel_q, rem_sel_d;

   logic             accept;
   logic             ctrl_hi_zero;
   alu_op_t          op;
   logic [WIDTH-1:0] fast_res;
   logic             fast_eq;
   logic             fast_dbz;
   logic             div_start;
   logic             div_busy;
   logic             div_done;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;

   // Any set bit above the encoded field makes the op undefined.
   assign ctrl_hi_zero = ((ALUctrl >> OP_W) == '0);
   assign op           = alu_op_t'(OP_W'(ALUctrl));

   assign in_ready  = (state_q == StIdle) && (!out_valid_q || out_ready);
   assign accept    = in_valid && in_ready;
   assign div_start = accept && ctrl_hi_zero && is_div_op(op) && (ALUop2 != '0);

   always_comb begin
      fast_res = '0;
      fast_eq  = 1'b0;
      fast_dbz = 1'b0;
      if (ctrl_hi_zero) begin
         case (op)
            OpAdd: fast_res = ALUop1 + ALUop2;
            OpSub: fast_res = ALUop1 - ALUop2;
            OpMul: fast_res = ALUop1 * ALUop2;
            OpAbs: fast_res = {1'b0, ALUop1[WIDTH-2:0]};
            OpSlt: fast_res = (ALUop1 < ALUop2) ? WIDTH'(1) : '0;
            OpSeq: begin
               fast_eq  = (ALUop1 == ALUop2);
               fast_res = fast_eq ? WIDTH'(1) : '0;
            end
            OpMin: fast_res = (ALUop1 < ALUop2) ? ALUop1 : ALUop2;
            // Only the divide-by-zero case of DIV/REM completes on the fast path.
            OpDiv: begin
               fast_res = '1;
               fast_dbz = 1'b1;
            end
            OpRem: begin
               fast_res = ALUop1;
               fast_dbz = 1'b1;
            end
            default: fast_res = '0;
         endcase
      end
   end

   alu_divider #(
      .WIDTH (WIDTH)
   ) u_divider (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (div_start),
      .hold      (out_valid_q && !out_ready),
      .dividend  (ALUop1),
      .divisor   (ALUop2),
      .busy      (div_busy),
      .done      (div_done),
      .quotient  (quotient),
      .remainder (remainder)
   );

   always_comb begin
      state_d     = state_q;
      out_valid_d = out_valid_q && !out_ready;
      res_d       = res_q;
      eq_d        = eq_q;
      dbz_d       = dbz_q;
      rem_sel_d   = rem_sel_q;
      case (state_q)
         StIdle: begin
            if (div_start) begin
               state_d   = StDiv;
               rem_sel_d = (op == OpRem);
            end else if (accept) begin
               out_valid_d = 1'b1;
               res_d       = fast_res;
               eq_d        = fast_eq;
               dbz_d       = fast_dbz;
            end
         end
         StDiv: begin
            if (div_done) begin
               state_d     = StIdle;
               out_valid_d = 1'b1;
               res_d       = rem_sel_q ? remainder : quotient;
               eq_d        = 1'b0;
               dbz_d       = 1'b0;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         out_valid_q <= 1'b0;
         res_q       <= '0;
         eq_q        <= 1'b0;
         dbz_q       <= 1'b0;
         rem_sel_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         out_valid_q <= out_valid_d;
         res_q       <= res_d;
         eq_q        <= eq_d;
         dbz_q       <= dbz_d;
         rem_sel_q   <= rem_sel_d;
      end
   end

   assign out_valid   = out_valid_q;
   assign Result      = res_q;
   assign EQ          = eq_q;
   assign div_by_zero = dbz_q;
   assign busy        = div_busy;

endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: directed plus randomized checks of alu_mc (WIDTH=32) against an arithmetic model.
module tb_alu_mc;

   localparam int unsigned W = 32;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] ALUop1 = '0;
   logic [W-1:0] ALUop2 = '0;
   logic [3:0]   ALUctrl = '0;
   logic         out_valid;
   logic         out_ready = 1'b1;
   logic [W-1:0] Result;
   logic         EQ;
   logic         div_by_zero;
   logic         busy;

   int n_vec = 0;
   int n_err = 0;

   alu_mc #(
      .WIDTH  (W),
      .CTRL_W (4)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .ALUop1      (ALUop1),
      .ALUop2      (ALUop2),
      .ALUctrl     (ALUctrl),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .Result      (Result),
      .EQ          (EQ),
      .div_by_zero (div_by_zero),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   // Reference: results straight from the arithmetic meaning of each op.
   function automatic void model(input logic [3:0] op, input logic [W-1:0] a,
                                 input logic [W-1:0] b, output logic [W-1:0] r,
                                 output logic e, output logic z, output int lat);
      longint unsigned la = a;
      longint unsigned lb = b;
      r = '0; e = 1'b0; z = 1'b0; lat = 0;
      case (op)
         4'd0: r = W'((la + lb) % (64'd1 << W));
         4'd1: r = W'((la + (64'd1 << W) - lb) % (64'd1 << W));
         4'd2: r = W'((la * lb) % (64'd1 << W));
         4'd3: if (lb == 0) begin r = '1; z = 1'b1; end else begin r = W'(la / lb); lat = W; end
         4'd4: r = W'(la % (64'd1 << (W - 1)));
         4'd5: r = (la < lb) ? W'(1) : W'(0);
         4'd6: begin e = (la == lb); r = e ? W'(1) : W'(0); end
         4'd7: r = (la < lb) ? a : b;
         4'd8: if (lb == 0) begin r = a; z = 1'b1; end else begin r = W'(la % lb); lat = W; end
         default: r = '0;
      endcase
   endfunction

   // Issue one op, wait for its result, check it, hold it under back-pressure, consume it.
   task automatic run_op(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input int hold);
      logic [W-1:0] r;
      logic         e, z;
      int           lat, k;
      model(op, a, b, r, e, z, lat);
      ALUctrl = op; ALUop1 = a; ALUop2 = b; in_valid = 1'b1;
      k = 0;
      while (!in_ready && k < 100) begin tick(); k++; end
      chk1({tag, ".in_ready"}, in_ready, 1'b1);
      tick();
      in_valid = 1'b0;
      k = 0;
      while (!out_valid && k < W + 8) begin
         chk1({tag, ".in_ready_busy"}, in_ready, 1'b0);
         tick();
         k++;
      end
      chk({tag, ".latency"}, W'(k), W'(lat));
      chk1({tag, ".out_valid"}, out_valid, 1'b1);
      out_ready = 1'b0;
      for (int i = 0; i <= hold; i++) begin
         chk({tag, ".Result"}, Result, r);
         chk1({tag, ".EQ"}, EQ, e);
         chk1({tag, ".div_by_zero"}, div_by_zero, z);
         if (i < hold) tick();
      end
      out_ready = 1'b1;
      tick();
      chk1({tag, ".released"}, out_valid, 1'b0);
   endtask

   initial begin
      logic [3:0]   rop;
      logic [W-1:0] ra, rb;

      // Reset state
      #2;
      chk1("rst.out_valid", out_valid, 1'b0);
      chk("rst.Result", Result, '0);
      chk1("rst.EQ", EQ, 1'b0);
      chk1("rst.div_by_zero", div_by_zero, 1'b0);
      chk1("rst.busy", busy, 1'b0);
      tick();
      rst_n = 1'b1;
      tick();

      // Fast ops and wrap
      run_op("add_wrap", 4'd0, 32'hFFFF_FFFF, 32'd2, 0);
      run_op("sub_wrap", 4'd1, 32'd3, 32'd5, 0);

      // Iterative divide, then divide by zero
      run_op("div", 4'd3, 32'd100, 32'd7, 0);
      run_op("rem", 4'd8, 32'd100, 32'd7, 1);
      run_op("div0", 4'd3, 32'd5, 32'd0, 0);
      run_op("rem0", 4'd8, 32'd5, 32'd0, 0);

      // Back-pressure on SEQ, then pass-through accept on release
      out_ready = 1'b0;
      ALUctrl = 4'd6; ALUop1 = 32'd7; ALUop2 = 32'd7; in_valid = 1'b1;
      chk1("seq.in_ready", in_ready, 1'b1);
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         chk1("bp.out_valid", out_valid, 1'b1);
         chk("bp.Result", Result, 32'd1);
         chk1("bp.EQ", EQ, 1'b1);
         chk1("bp.in_ready", in_ready, 1'b0);
         tick();
      end
      ALUctrl = 4'd0; ALUop1 = 32'd1; ALUop2 = 32'd1; in_valid = 1'b1; out_ready = 1'b1;
      #1;
      chk1("pass.in_ready", in_ready, 1'b1);
      tick();
      in_valid = 1'b0;
      chk1("pass.out_valid", out_valid, 1'b1);
      chk("pass.Result", Result, 32'd2);
      chk1("pass.EQ", EQ, 1'b0);
      tick();
      chk1("pass.released", out_valid, 1'b0);

      // Reset in the middle of a divide
      ALUctrl = 4'd3; ALUop1 = 32'hFFFF_FFFF; ALUop2 = 32'd3; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 10; i++) tick();
      chk1("middiv.busy", busy, 1'b1);
      rst_n = 1'b0;
      #1;
      chk1("abort.busy", busy, 1'b0);
      chk1("abort.out_valid", out_valid, 1'b0);
      chk("abort.Result", Result, '0);
      chk1("abort.div_by_zero", div_by_zero, 1'b0);
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < W + 2; i++) begin
         chk1("abort.no_output", out_valid, 1'b0);
         tick();
      end
      run_op("min_after_rst", 4'd7, 32'd9, 32'd4, 0);

      // Undefined encoding
      run_op("undef", 4'hF, 32'h1234_5678, 32'h1234_5678, 0);

      // Randomized ops against the model
      for (int n = 0; n < 40; n++) begin
         rop = 4'($urandom_range(0, 9));
         if (rop == 4'd9) rop = 4'($urandom_range(9, 15));
         ra = $urandom();
         rb = $urandom();
         if ($urandom_range(0, 3) == 0) rb = W'($urandom_range(0, 9));
         if ($urandom_range(0, 7) == 0) rb = ra;
         run_op("rand", rop, ra, rb, int'($urandom_range(0, 2)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout vectors=%0d miscompares=%0d", n_vec, n_err);
      $fatal(1, "simulation time limit reached");
   end

endmodule
